// File: rtl/cdt_trig_pkg.sv
// Shared types for the CDT trigger path: scheduler FSM states and the
// dead-time counter width.
package cdt_trig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DEAD  = 2'd2
    } trig_state_e;

    localparam int CNT_W = 8;

endpackage

// File: rtl/trig_edge_det.sv
// Registered rising-edge detector for one trigger line. The line is sampled
// once, then compared against its previous sample; both reset high.
module trig_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic din_q;
    logic prev;

    // Resetting high means a line already asserted at reset release is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            din_q <= 1'b1;
            prev  <= 1'b1;
            rise  <= 1'b0;
        end else begin
            din_q <= din;
            prev  <= din_q;
            rise  <= din_q & ~prev;
        end
    end

endmodule

// File: rtl/trig_rr_scheduler.sv
// Latches rising edges from N_SRC trigger lines and issues them one at a time,
// round-robin, on a single valid/ack port with a dead-time after each ack.
module trig_rr_scheduler
    import cdt_trig_pkg::*;
#(
    parameter int N_SRC    = 4,
    parameter int ID_W     = 2,
    parameter int DEADTIME = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N_SRC-1:0]  src_in,
    output logic              trig_valid,
    output logic [ID_W-1:0]   trig_id,
    input  logic              trig_ack,
    input  logic              clr_ovf,
    output logic [N_SRC-1:0]  pending,
    output logic [N_SRC-1:0]  ovf,
    output logic [1:0]        state_dbg
);

    // Handshake: trig_valid/trig_id are held stable until a cycle in which
    // trig_valid and trig_ack are both high; that cycle is the transfer.

    logic [N_SRC-1:0] rise_v;
    logic [N_SRC-1:0] pending_q, pending_n;
    logic [N_SRC-1:0] ovf_q, ovf_n;
    logic [N_SRC-1:0] set_mask, clr_mask;
    logic             ack_fire;

    trig_state_e      state_q, state_n;
    logic             valid_q, valid_n;
    logic [ID_W-1:0]  id_q, id_n;
    logic [ID_W-1:0]  last_q, last_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;

    logic             hi_found, lo_found;
    logic [ID_W-1:0]  hi_idx, lo_idx, win;

    for (genvar g = 0; g < N_SRC; g++) begin : g_edge
        trig_edge_det u_det (
            .clk  (clk),
            .rst  (rst),
            .din  (src_in[g]),
            .rise (rise_v[g])
        );
    end

    assign ack_fire = (state_q == ST_ISSUE) && trig_ack;
    assign set_mask = rise_v & {N_SRC{en}};
    assign clr_mask = ack_fire ? (N_SRC'(1) << id_q) : '0;

    // A new edge beats the clear of its own ack, so it counts as a fresh trigger.
    assign pending_n = set_mask | (pending_q & ~clr_mask);
    assign ovf_n     = (set_mask & pending_q & ~clr_mask) | (ovf_q & ~{N_SRC{clr_ovf}});

    // Round-robin: lowest pending index above last, else lowest at or below it.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (pending_q[i[ID_W-1:0]]) begin
                if (ID_W'(i) > last_q) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = ID_W'(i);
                end
            end
        end
        win = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        state_n = state_q;
        valid_n = valid_q;
        id_n    = id_q;
        last_n  = last_q;
        cnt_n   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (en && (hi_found || lo_found)) begin
                    id_n    = win;
                    valid_n = 1'b1;
                    state_n = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (trig_ack) begin
                    valid_n = 1'b0;
                    last_n  = id_q;
                    if (DEADTIME == 0) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_DEAD;
                        cnt_n   = CNT_W'(DEADTIME);
                    end
                end
            end
            ST_DEAD: begin
                cnt_n = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
                valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            valid_q   <= 1'b0;
            id_q      <= '0;
            last_q    <= ID_W'(N_SRC - 1);
            cnt_q     <= '0;
            pending_q <= '0;
            ovf_q     <= '0;
        end else begin
            state_q   <= state_n;
            valid_q   <= valid_n;
            id_q      <= id_n;
            last_q    <= last_n;
            cnt_q     <= cnt_n;
            pending_q <= pending_n;
            ovf_q     <= ovf_n;
        end
    end

    assign trig_valid = valid_q;
    assign trig_id    = id_q;
    assign pending    = pending_q;
    assign ovf        = ovf_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_trig_rr_scheduler.sv
// Bench for trig_rr_scheduler: table of multi-source bursts plus hand-written
// sequences for latency, overflow, same-cycle re-trigger, enable and reset.
module tb_trig_rr_scheduler;
    import cdt_trig_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic [3:0] src_in = 4'b0;
    logic       trig_valid;
    logic [1:0] trig_id;
    logic       trig_ack = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [3:0] pending;
    logic [3:0] ovf;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [1:0] exp_q[$];

    logic mon_v = 1'b0, mon_a = 1'b0, mon_r = 1'b1;

    typedef struct packed {
        logic [3:0]      rise;
        logic [2:0]      n;
        logic [3:0][1:0] ids;
    } vec_t;

    vec_t vecs [6];

    trig_rr_scheduler #(.N_SRC(4), .ID_W(2), .DEADTIME(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .src_in     (src_in),
        .trig_valid (trig_valid),
        .trig_id    (trig_id),
        .trig_ack   (trig_ack),
        .clr_ovf    (clr_ovf),
        .pending    (pending),
        .ovf        (ovf),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // valid may only fall after a sampled ack or under reset
    always @(negedge clk) begin
        if (mon_v && !trig_valid) chk("valid_drop_without_ack", {31'b0, mon_a | mon_r}, 32'd1);
        mon_v <= trig_valid;
        mon_a <= trig_ack;
        mon_r <= rst;
    end

    task automatic pulse(input logic [3:0] m);
        src_in = m;
        tick();
        tick();
        src_in = 4'b0;
        tick();
    endtask

    task automatic wait_valid(input int budget, output int start);
        int k = 0;
        while (!trig_valid && k < budget) begin
            tick();
            k++;
        end
        chk("valid_seen", {31'b0, trig_valid}, 32'd1);
        start = cyc;
    endtask

    task automatic take(input int hold);
        logic [1:0] id0;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_grant: got id %0d want no grant", trig_id);
        end else begin
            chk("grant_id", trig_id, exp_q.pop_front());
        end
        id0 = trig_id;
        for (int k = 0; k < hold; k++) begin
            tick();
            chk("hold_valid", trig_valid, 1);
            chk("hold_id", trig_id, id0);
        end
        trig_ack = 1'b1;
        tick();
        trig_ack = 1'b0;
        chk("valid_after_ack", trig_valid, 0);
    endtask

    task automatic quiet(input int n);
        int hits = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (trig_valid) hits++;
        end
        chk("no_extra_grant", hits, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, s1, s2, a;

        // grant order below follows the round-robin pointer left by the
        // preceding vector (last = 2 on entry)
        vecs[0] = '{rise: 4'b1111, n: 3'd4, ids: {2'd2, 2'd1, 2'd0, 2'd3}};
        vecs[1] = '{rise: 4'b0001, n: 3'd1, ids: {2'd0, 2'd0, 2'd0, 2'd0}};
        vecs[2] = '{rise: 4'b0101, n: 3'd2, ids: {2'd0, 2'd0, 2'd0, 2'd2}};
        vecs[3] = '{rise: 4'b1010, n: 3'd2, ids: {2'd0, 2'd0, 2'd3, 2'd1}};
        vecs[4] = '{rise: 4'b0110, n: 3'd2, ids: {2'd0, 2'd0, 2'd2, 2'd1}};
        vecs[5] = '{rise: 4'b1001, n: 3'd2, ids: {2'd0, 2'd0, 2'd0, 2'd3}};

        // reset with lines 0 and 2 already high
        rst = 1'b1;
        src_in = 4'b0101;
        repeat (4) tick();
        chk("rst_valid", trig_valid, 0);
        chk("rst_id", trig_id, 0);
        chk("rst_pending", pending, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_state", state_dbg, 32'(ST_IDLE));
        rst = 1'b0;
        repeat (6) tick();
        chk("held_high_valid", trig_valid, 0);
        chk("held_high_pending", pending, 0);
        src_in = 4'b0;
        repeat (3) tick();
        chk("low_again_pending", pending, 0);

        // simultaneous 0,1,3 with zero-wait acks: spacing DEADTIME+2
        pulse(4'b1011);
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
        wait_valid(20, s0);
        take(0);
        wait_valid(20, s1);
        take(0);
        chk("spacing_0_1", s1 - s0, 10);
        wait_valid(20, s2);
        take(0);
        chk("spacing_1_3", s2 - s1, 10);
        quiet(12);
        chk("burst_pending", pending, 0);

        // single rise on source 2: exact latency and dead-time
        src_in = 4'b0100;
        tick();
        tick();
        chk("lat_t1_pending", pending, 0);
        chk("lat_t1_valid", trig_valid, 0);
        tick();
        chk("lat_t2_pending", pending, 4'b0100);
        chk("lat_t2_valid", trig_valid, 0);
        tick();
        chk("lat_t3_valid", trig_valid, 1);
        src_in = 4'b0;
        exp_q.push_back(2'd2);
        take(0);
        chk("ack_pending", pending, 0);
        chk("ack_state", state_dbg, 32'(ST_DEAD));
        trig_ack = 1'b1;
        quiet(8);
        trig_ack = 1'b0;
        chk("dead_end_state", state_dbg, 32'(ST_IDLE));

        for (int v = 0; v < 6; v++) begin
            pulse(vecs[v].rise);
            for (int j = 0; j < int'(vecs[v].n); j++) exp_q.push_back(vecs[v].ids[j]);
            for (int j = 0; j < int'(vecs[v].n); j++) begin
                wait_valid(40, s0);
                if (trig_valid) take(int'($urandom_range(0, 2)));
            end
            quiet(12);
            chk("vec_pending", pending, 0);
            chk("vec_queue_empty", exp_q.size(), 0);
        end

        // source 1 edges twice while pending behind a held grant of source 0
        pulse(4'b0001);
        exp_q.push_back(2'd0);
        wait_valid(20, s0);
        pulse(4'b0010);
        pulse(4'b0010);
        chk("ovf_pending", pending, 4'b0011);
        chk("ovf_set", ovf, 4'b0010);
        take(0);
        exp_q.push_back(2'd1);
        wait_valid(20, s0);
        take(0);
        quiet(12);
        chk("ovf_single_grant_pending", pending, 0);
        chk("ovf_sticky", ovf, 4'b0010);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_cleared", ovf, 0);

        // edge on the granted source lands in the same cycle as its ack
        pulse(4'b0100);
        exp_q.push_back(2'd2);
        wait_valid(20, s0);
        chk("same_grant_id", trig_id, exp_q.pop_front());
        src_in = 4'b0100;
        tick();
        src_in = 4'b0;
        tick();
        trig_ack = 1'b1;
        tick();
        trig_ack = 1'b0;
        a = cyc;
        chk("same_valid_low", trig_valid, 0);
        chk("same_pending_kept", pending, 4'b0100);
        chk("same_no_ovf", ovf, 0);
        exp_q.push_back(2'd2);
        wait_valid(20, s1);
        chk("same_regrant_delay", s1 - a, 9);
        take(0);
        quiet(12);
        chk("same_pending_done", pending, 0);

        // en low: no latching, and no new grant while low
        en = 1'b0;
        pulse(4'b0001);
        tick();
        chk("en_low_no_latch", pending, 0);
        en = 1'b1;
        pulse(4'b0110);
        exp_q.push_back(2'd1);
        wait_valid(20, s0);
        en = 1'b0;
        take(0);
        quiet(15);
        chk("en_low_retained", pending, 4'b0100);
        en = 1'b1;
        exp_q.push_back(2'd2);
        wait_valid(20, s0);
        take(0);
        quiet(12);

        // reset during ISSUE of source 3, then pointer must be back at 3
        pulse(4'b1010);
        exp_q.push_back(2'd3);
        wait_valid(20, s0);
        chk("rst_mid_id", trig_id, exp_q.pop_front());
        rst = 1'b1;
        tick();
        chk("rst_mid_valid", trig_valid, 0);
        chk("rst_mid_pending", pending, 0);
        chk("rst_mid_ovf", ovf, 0);
        chk("rst_mid_state", state_dbg, 32'(ST_IDLE));
        rst = 1'b0;
        quiet(4);
        pulse(4'b1001);
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd3);
        wait_valid(20, s0);
        take(0);
        wait_valid(20, s0);
        take(0);
        quiet(12);
        chk("post_rst_pending", pending, 0);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
